mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS datapath (MULT, DIV).
- Sits downstream of the ALU operand selection: consumes register operands A and B and writes the HI/LO result registers read by MFHI/MFLO.
- The control FSM issues a one-cycle start and waits for done or div_zero before advancing.
- Unit is sequential: shift-add multiply, restoring divide, one iteration per cycle.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- start_mult  input  1  one-cycle request: signed A*B
- start_div  input  1  one-cycle request: signed A/B
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- HI  output  WIDTH  mult: product[63:32]; div: remainder
- LO  output  WIDTH  mult: product[31:0]; div: quotient
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, HI/LO valid
- div_zero  output  1  one-cycle pulse, divide by zero detected

Behaviour:
- Reset is synchronous, active-high, on clk. It forces state IDLE and HI=LO=0, busy=0, done=0, div_zero=0.
- Reset mid-operation aborts the operation. The partial result is discarded and HI/LO are cleared.
- FSM states: IDLE, LOAD, RUN, FIX, DONE.
- IDLE, start sampled at edge N:
  - A and B are latched. Starts arriving while busy=1 are ignored.
  - If both starts are high together, start_mult wins.
  - start_div with B==0: go to DONE_ZERO handling, not LOAD. div_zero=1 for cycle N+1, busy stays 0, HI/LO unchanged, back to IDLE.
  - Otherwise go to LOAD; busy=1 from cycle N+1.
- LOAD (1 cycle): record the sign flags, take magnitudes |A| and |B|, clear the accumulator, counter=0.
- RUN (WIDTH cycles):
  - Mult: unsigned shift-add, 2*WIDTH accumulator.
  - Div: unsigned restoring; shift the remainder left, subtract the divisor, set the quotient bit when the result is non-negative.
  - Counter increments each cycle; leave RUN when counter==WIDTH-1.
- FIX (1 cycle), two's-complement sign correction:
  - Mult: negate the 64-bit product if sign(A) xor sign(B).
  - Div: negate the quotient if sign(A) xor sign(B); negate the remainder if sign(A). Remainder takes the dividend's sign, quotient truncates toward zero.
- DONE (1 cycle):
  - HI/LO are registered at the edge entering DONE.
  - done=1 and busy=0 in DONE; return to IDLE next edge.
- Latency: start at edge N gives done high during cycle N+WIDTH+3, i.e. N+35 for WIDTH=32. HI/LO hold their value until the next completed operation or reset.
- Overflow case -2^31 / -1: no exception. LO=0x80000000 (wrapped), HI=0.
- Magnitude of -2^31 is handled as unsigned 0x80000000; no overflow in either the mult or div path.
- A and B may change after the start cycle without affecting the result (latched).
- done and div_zero are never high in the same cycle.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, LOAD, RUN, FIX, DONE)
  - OP_MULT/OP_DIV op select
  - WIDTH default
- One natural sub-module, div_step: a combinational restoring-division step (remainder, divisor in; next remainder and quotient bit out), instantiated once.
- The multiply path stays inline.

Test Plan:
- Mult positive: A=7, B=6, start_mult -> done at N+35; HI=0x00000000, LO=0x0000002A; busy high N+1..N+34.
- Mult signed: A=0xFFFFFFFF (-1), B=0x80000000 -> HI=0x00000000, LO=0x80000000. Also A=-3, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Div signed: A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then A=7, B=-2 -> LO=-3, HI=1. Then A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Div by zero: HI/LO preloaded from a prior op, A=5, B=0, start_div -> div_zero=1 at N+1 only; busy stays 0; done never pulses; HI/LO unchanged.
- Busy/priority: start_div pulsed at N+10 during a mult -> ignored, mult result correct. Both starts high together -> multiply performed.
- Reset mid-op: reset=1 at N+15 of a mult -> next cycle busy=0, HI=LO=0; no done. A new start_mult after reset completes normally in 35 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the FSM state encoding, the operation select and the default
// operand width used by the top level and the divide step.
package mult_div_unit_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One unsigned restoring-division step, purely combinational.
// Latency: none. Backpressure: none (no handshake).
// Ports: rem_in   - partial remainder before this step
//        bit_in   - next dividend bit shifted into the remainder
//        divisor  - unsigned divisor magnitude
//        rem_out  - partial remainder after this step
//        q_bit    - quotient bit produced by this step
module mult_div_unit_div_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction succeeds the result is below the divisor, so the
  // low WIDTH bits of the modular difference are exact.
  assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: start sampled at edge N -> done pulse in cycle N+WIDTH+3.
// Backpressure: starts seen while an operation is in flight are dropped.
// Ports: clk, reset (sync, active-high)
//        start_mult/start_div - one-cycle requests (mult wins if both)
//        A, B                 - operands, latched on the accepted start
//        HI, LO               - mult: product high/low; div: remainder/quotient
//        busy, done, div_zero - status; done/div_zero are one-cycle pulses
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t             state;
  op_t                op;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // mult: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [CNT_W-1:0]   cnt;
  logic               sign_a;
  logic               sign_b;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_q;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Negating the most negative value yields the same bit pattern, which is
  // exactly its unsigned magnitude.
  assign abs_a = a_q[WIDTH-1] ? -a_q : a_q;
  assign abs_b = b_q[WIDTH-1] ? -b_q : b_q;

  // Carry out of the add becomes the top bit of the right-shifted accumulator.
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

  mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc[2*WIDTH-1:WIDTH]),
    .bit_in  (acc[WIDTH-1]),
    .divisor (opnd),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  assign prod_neg = -acc;

  // Sign correction: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (op == OP_MULT) begin
      if (sign_a ^ sign_b) begin
        fix_hi = prod_neg[2*WIDTH-1:WIDTH];
        fix_lo = prod_neg[WIDTH-1:0];
      end
    end else begin
      if (sign_a ^ sign_b) fix_lo = -acc[WIDTH-1:0];
      if (sign_a)          fix_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op       <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            a_q   <= A;
            b_q   <= B;
            op    <= OP_MULT;
            busy  <= 1'b1;
            state <= LOAD;
          end else if (start_div) begin
            if (B == '0) begin
              // Flag and stay idle; HI/LO keep the previous result.
              div_zero <= 1'b1;
            end else begin
              a_q   <= A;
              b_q   <= B;
              op    <= OP_DIV;
              busy  <= 1'b1;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          sign_a <= a_q[WIDTH-1];
          sign_b <= b_q[WIDTH-1];
          cnt    <= '0;
          if (op == OP_MULT) begin
            opnd <= abs_a;
            acc  <= {{WIDTH{1'b0}}, abs_b};
          end else begin
            opnd <= abs_b;
            acc  <= {{WIDTH{1'b0}}, abs_a};
          end
          state <= RUN;
        end
        RUN: begin
          if (op == OP_MULT) acc <= {add_sum, acc[WIDTH-1:1]};
          else               acc <= {div_rem, acc[WIDTH-2:0], div_q};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_zero;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .A          (A),
    .B          (B),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  // Reference: signed arithmetic on 64-bit integers.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Drives one request (mode 0 mult, 1 div, 2 both) from #1 after an edge and
  // observes until done; inj>0 pulses start_div in cycle N+inj.
  task automatic do_op(input int mode, input logic [31:0] a, input logic [31:0] b, input int inj,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo,
                       output bit busy_ok, output bit dz_seen);
    lat = -1; busy_ok = 1'b1; dz_seen = 1'b0;
    A = a; B = b;
    start_mult = (mode != 1);
    start_div  = (mode != 0);
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    A = $urandom; B = $urandom;
    for (int k = 1; k <= 60; k++) begin
      if (div_zero) dz_seen = 1'b1;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      start_div = (k == inj);
      @(posedge clk); #1;
    end
    start_div = 1'b0;
    hi = HI; lo = LO;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; A = '1; B = '1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0)     begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    vectors++; if ({HI, LO} !== 64'd0) begin miscompares++; $display("FAIL reset_hilo: got %h_%h expected 0", HI, LO); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_directed();
    logic [31:0] a, b, eh, el, hi, lo;
    int lat; bit bok, dz;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'd7;        b = 32'd6;        eh = 32'h0;        el = 32'h2A;       end
        1:       begin a = 32'hFFFFFFFF; b = 32'h80000000; eh = 32'h0;        el = 32'h80000000; end
        default: begin a = 32'hFFFFFFFD; b = 32'd5;        eh = 32'hFFFFFFFF; el = 32'hFFFFFFF1; end
      endcase
      do_op(0, a, b, 0, lat, hi, lo, bok, dz);
      vectors++; if (lat !== 35) begin miscompares++; $display("FAIL mult_latency[%0d]: got %0d expected 35", i, lat); end
      vectors++; if ({hi, lo} !== {eh, el}) begin miscompares++; $display("FAIL mult_result[%0d]: got %h_%h expected %h_%h", i, hi, lo, eh, el); end
      vectors++; if (!bok || dz) begin miscompares++; $display("FAIL mult_status[%0d]: busy_ok=%b div_zero_seen=%b expected 1/0", i, bok, dz); end
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] a, b, eh, el, hi, lo;
    int lat; bit bok, dz;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'hFFFFFFF9; b = 32'd2;        eh = 32'hFFFFFFFF; el = 32'hFFFFFFFD; end
        1:       begin a = 32'd7;        b = 32'hFFFFFFFE; eh = 32'd1;        el = 32'hFFFFFFFD; end
        default: begin a = 32'h80000000; b = 32'hFFFFFFFF; eh = 32'h0;        el = 32'h80000000; end
      endcase
      do_op(1, a, b, 0, lat, hi, lo, bok, dz);
      vectors++; if (lat !== 35) begin miscompares++; $display("FAIL div_latency[%0d]: got %0d expected 35", i, lat); end
      vectors++; if ({hi, lo} !== {eh, el}) begin miscompares++; $display("FAIL div_result[%0d]: got %h_%h expected %h_%h", i, hi, lo, eh, el); end
      vectors++; if (!bok || dz) begin miscompares++; $display("FAIL div_status[%0d]: busy_ok=%b div_zero_seen=%b expected 1/0", i, bok, dz); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eh, el, hi, lo;
    int lat; bit bok, dz, is_div;
    for (int i = 0; i < 24; i++) begin
      is_div = bit'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF - $urandom_range(0, 20);
        2:       a = $urandom_range(0, 40);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'h80000000;
        1:       b = 32'hFFFFFFFF - $urandom_range(0, 20);
        2:       b = $urandom_range(1, 40);
        default: b = $urandom;
      endcase
      if (is_div && b == 32'd0) b = 32'd3;
      model(is_div, a, b, eh, el);
      do_op(is_div ? 1 : 0, a, b, 0, lat, hi, lo, bok, dz);
      vectors++; if (lat !== 35) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected 35", i, lat); end
      vectors++;
      if ({hi, lo} !== {eh, el}) begin
        miscompares++;
        $display("FAIL rand_result[%0d] div=%0b a=%h b=%h: got %h_%h expected %h_%h", i, is_div, a, b, hi, lo, eh, el);
      end
      vectors++; if (!bok || dz) begin miscompares++; $display("FAIL rand_status[%0d]: busy_ok=%b div_zero_seen=%b expected 1/0", i, bok, dz); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    int lat; bit bok, dz, bad;
    do_op(0, 32'd7, 32'd6, 0, lat, hi, lo, bok, dz);
    A = 32'd5; B = 32'd0; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_pulse: got %b expected 1", div_zero); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL dz_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0)     begin miscompares++; $display("FAIL dz_done: got %b expected 0", done); end
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (div_zero || done || busy) bad = 1'b1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL dz_after: got activity expected quiet"); end
    vectors++; if ({HI, LO} !== {32'h0, 32'h2A}) begin miscompares++; $display("FAIL dz_hilo: got %h_%h expected 00000000_0000002a", HI, LO); end
  endtask

  task automatic test_busy_priority();
    logic [31:0] eh, el, hi, lo;
    int lat; bit bok, dz;
    model(1'b0, 32'd9, 32'hFFFFFFFC, eh, el);
    do_op(0, 32'd9, 32'hFFFFFFFC, 10, lat, hi, lo, bok, dz);
    vectors++; if (lat !== 35) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 35", lat); end
    vectors++; if ({hi, lo} !== {eh, el}) begin miscompares++; $display("FAIL ignore_result: got %h_%h expected %h_%h", hi, lo, eh, el); end
    // The pulse landed during the mult; nothing should follow it.
    repeat (40) begin
      if (busy || done) begin
        miscompares++; vectors++;
        $display("FAIL ignore_followup: got busy=%b done=%b expected idle", busy, done);
        break;
      end
      @(posedge clk); #1;
    end
    model(1'b0, 32'hFFFFFFFB, 32'd3, eh, el);
    do_op(2, 32'hFFFFFFFB, 32'd3, 0, lat, hi, lo, bok, dz);
    vectors++; if (lat !== 35) begin miscompares++; $display("FAIL both_latency: got %0d expected 35", lat); end
    vectors++; if ({hi, lo} !== {eh, el}) begin miscompares++; $display("FAIL both_result: got %h_%h expected %h_%h", hi, lo, eh, el); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] eh, el, hi, lo;
    int lat; bit bok, dz, bad;
    do_op(0, 32'd7, 32'd6, 0, lat, hi, lo, bok, dz);
    A = 32'd123; B = 32'hFFFFFE38; start_mult = 1'b1;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midop_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midop_busy: got %b expected 0", busy); end
    vectors++; if ({HI, LO} !== 64'd0) begin miscompares++; $display("FAIL midop_hilo: got %h_%h expected 0", HI, LO); end
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) bad = 1'b1;
      @(posedge clk); #1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL midop_no_done: got activity expected quiet"); end
    model(1'b0, 32'd123, 32'hFFFFFE38, eh, el);
    do_op(0, 32'd123, 32'hFFFFFE38, 0, lat, hi, lo, bok, dz);
    vectors++; if (lat !== 35) begin miscompares++; $display("FAIL midop_restart_latency: got %0d expected 35", lat); end
    vectors++; if ({hi, lo} !== {eh, el}) begin miscompares++; $display("FAIL midop_restart_result: got %h_%h expected %h_%h", hi, lo, eh, el); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div_zero();
    test_busy_priority();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
